regfile_write_arbiter: RTL

- Shares the register file's single write port between NUM_REQ writeback requesters, e.g. ALU result and memory-load return.
- Uses round-robin arbitration, a one-cycle registered write stage and a 32-entry pending-write scoreboard.
- The scoreboard flags read-after-write hazards for the two register read addresses.
- Sits between the writeback sources and the register file write port (reg_write / write_reg_address / write_data).

---
 rtl/regfile_write_arbiter_pkg.sv | 9 +
 rtl/regfile_write_arbiter_rr_arbiter.sv | 45 ++++
 rtl/regfile_write_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants for the writeback arbiter and the register file.
package regfile_write_arbiter_pkg;

  localparam int REG_COUNT      = 32;
  localparam int ZERO_REG       = 0;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the search starts at ptr and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] winner;
  logic             found;
  int               idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!reset && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        winner     = PTR_W'(idx);
        found      = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among writeback sources and tracks
// pending destinations so the issue stage can detect read-after-write hazards.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      reserve_valid,
  input  logic [ADDR_W-1:0]         reserve_addr,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_hazard,
  output logic                      rs2_hazard,
  output logic                      rf_reg_write,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic [REG_COUNT-1:0]      pending
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic                 transfer;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_data;
  logic                 write_q;
  logic [REG_COUNT-1:0] pending_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   (req_valid),
    .advance (transfer),
    .grant   (req_ready)
  );

  assign transfer = |(req_valid & req_ready);

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Clear first, then set: a same-cycle reserve belongs to a newer producer.
  always_comb begin
    pending_next = pending;
    if (transfer && win_addr != ZERO_ADDR) pending_next[win_addr] = 1'b0;
    if (reserve_valid && reserve_addr != ZERO_ADDR) pending_next[reserve_addr] = 1'b1;
  end

  // NOTE: the pending vector is plain flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q       <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
      pending       <= '0;
    end else begin
      write_q <= transfer && (win_addr != ZERO_ADDR);
      if (transfer) begin
        rf_write_addr <= win_addr;
        rf_write_data <= win_data;
      end
      pending <= pending_next;
    end
  end

  // An in-flight write is dropped the moment reset is raised.
  assign rf_reg_write = write_q & ~reset;

  assign rs1_hazard = (rs1_addr != ZERO_ADDR) && pending[rs1_addr];
  assign rs2_hazard = (rs2_addr != ZERO_ADDR) && pending[rs2_addr];

endmodule
